mont_mult_serial: RTL and testbench
===================================

# mont_mult_serial

Bit-serial Montgomery modular multiplier for the RSA peripheral. Computes P = A·B·2^-WIDTH mod M, consuming multiplier A one bit per cycle, LSB first, from the parallel-load serializer directly upstream. It drives that serializer's `load` strobe itself, so the pair forms one modular-multiply stage under the exponentiation controller. Radix-2 interleaved reduction runs for WIDTH iterations, followed by one conditional final subtraction.

## Interface
- WIDTH, default 4, operand and modulus width in bits; must match the upstream serializer's WIDTH.
- rstb  input  1  asynchronous active-low reset
- clk  input  1  clock; all state changes on the rising edge
- ena  input  1  global clock enable, shared with the serializer; ena=0 freezes every register
- clear  input  1  synchronous active-low clear, effective only when ena=1, shared with the serializer
- start  input  1  request a multiply; sampled only in IDLE with ena=1
- B  input  WIDTH  multiplicand; must satisfy B < M
- M  input  WIDTH  modulus; must be odd
- A_bit  input  1  serial multiplier bit from the serializer (A[i] in iteration i)
- a_load  output  1  load strobe to the serializer; high exactly while in LOAD
- busy  output  1  high in LOAD, CALC and SUB
- done  output  1  one enabled-cycle pulse when P is valid
- P  output  WIDTH  result register; holds its value until the next completion

## Operation
- States: IDLE, LOAD, CALC, SUB. Reset state and clear state are IDLE.
- In IDLE, start=1 captures B and M into internal registers, zeroes accumulator R (WIDTH+2 bits) and iteration counter i, then moves to LOAD.
- While in LOAD, a_load=1, so the serializer captures A at the same edge. Next state is CALC.
- In CALC, iteration i uses a = A_bit:
  - t = R + (a ? B : 0)
  - q = t[0]
  - R ← (t + (q ? M : 0)) >> 1
  - i increments; after iteration WIDTH-1, move to SUB.
  - The serializer shifts on the same edges, since its load is low.
- Width rule: R < 2M holds throughout, so t + M < 4M fits in WIDTH+2 bits. No intermediate truncation is permitted.
- In SUB: P ← (R ≥ M) ? R − M : R, truncated to WIDTH bits. Set done=1 and return to IDLE. R = M must yield P = 0.
- start while busy is ignored.
- B and M changes after start has no effect on the running operation.
- clear=0 with ena=1, in any state: go to IDLE; R, i, P, done and busy become 0; a_load becomes 0. clear takes priority over start.
- rstb low, at any time including mid-operation: asynchronously set state IDLE and R, i, P, done, busy, a_load, captured B and M to 0.

## Timing
- Reset values: P=0, done=0, busy=0, a_load=0.
- Call the edge that samples start E0; it must have ena=1. Counting enabled edges from E0:
  - LOAD occupies the cycle after E0; the serializer loads at E1.
  - CALC iterations occur at E2 through E(WIDTH+1).
  - SUB occurs at E(WIDTH+2).
  - done=1 and P are valid in the cycle after E(WIDTH+2).
- Latency from start to done is WIDTH+2 enabled clocks.
- done drops at the next enabled edge.
- A new start is accepted in the cycle that done is high; its LOAD begins one cycle later.
- ena=0 cycles stretch the schedule: state, R, i, P, done and a_load all hold unchanged.
- The requester must hold A stable from start until E1.
- a_load and busy are decoded from state only, with no combinational path from start.

## Test plan
- WIDTH=4, M=13, B=11, A=7, start pulse → a_load high one cycle; done exactly 6 enabled cycles after the start edge; P=4. Intermediate R values are 12, 18, 21, 17.
- WIDTH=4, M=15, B=14, A=15 → pre-subtract R=15 (the R=M boundary); P=0.
- WIDTH=4, M=13, B=1, A=1 → P=9. Also A=0, B=12 → P=0, with done still pulsing at cycle 6.
- Same operands as the first case, with ena toggled 0/1 every other cycle → P=4; done arrives after 6 enabled edges and is held while ena=0.
- Fault handling:
  - Start the first case, then drive clear=0 at iteration 2 → state IDLE, P=0, busy=0, no done pulse.
  - Restart → P=4.
  - Repeat with rstb pulsed low mid-CALC → all outputs 0 immediately.
- Start held high through a whole operation, with B and M changed mid-run → only one result per accepted start; the first result is P=4, computed from the captured B and M; back-to-back starts are accepted in done cycles.

Source files
------------

// File: rtl/mont_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: P = A*B*2^-WIDTH mod M, with A streamed LSB first
// from an upstream serializer that this block loads through a_load.
module mont_mult_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] M,
    input  logic             A_bit,
    output logic             a_load,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] P
);
    // state | meaning
    // IDLE  | waiting for start; B and M captured on the start edge
    // LOAD  | serializer captures A on this cycle's edge
    // CALC  | one interleaved add/reduce iteration per enabled edge
    // SUB   | conditional final subtraction, result into P, done next cycle
    localparam int RW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_SUB} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [RW-1:0]   r_acc;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_m;
    logic [CW-1:0]   r_iter;
    logic [WIDTH-1:0] r_p;
    logic            r_done;

    logic [RW-1:0]   w_b_ext;
    logic [RW-1:0]   w_m_ext;
    logic [RW-1:0]   w_t;
    logic [RW-1:0]   w_sum;
    logic            w_last;
    logic            w_ge;

    assign w_b_ext = {2'b00, r_b};
    assign w_m_ext = {2'b00, r_m};
    // R < 2M keeps t + M below 4M, so RW bits never overflow
    assign w_t     = r_acc + (A_bit ? w_b_ext : '0);
    assign w_sum   = w_t + (w_t[0] ? w_m_ext : '0);
    assign w_last  = (r_iter == CW'(WIDTH - 1));
    assign w_ge    = (r_acc >= w_m_ext);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
        end else if (ena) begin
            if (!clear) r_state <= S_IDLE;
            else        r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_SUB;
            S_SUB:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        a_load = (r_state == S_LOAD);
        busy   = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_acc  <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_iter <= '0;
            r_p    <= '0;
            r_done <= 1'b0;
        end else if (ena) begin
            if (!clear) begin
                r_acc  <= '0;
                r_iter <= '0;
                r_p    <= '0;
                r_done <= 1'b0;
            end else begin
                r_done <= 1'b0;
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_b    <= B;
                            r_m    <= M;
                            r_acc  <= '0;
                            r_iter <= '0;
                        end
                    end
                    S_CALC: begin
                        r_acc  <= RW'(w_sum >> 1);
                        r_iter <= r_iter + CW'(1);
                    end
                    S_SUB: begin
                        r_p    <= WIDTH'(w_ge ? (r_acc - w_m_ext) : r_acc);
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign P    = r_p;
    assign done = r_done;

endmodule

// File: tb/tb_mont_mult_serial.sv
// Directed bench for mont_mult_serial with a behavioural model of the upstream A serializer.
module tb_mont_mult_serial;
    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rstb  = 1'b0;
    logic         ena   = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] B     = '0;
    logic [W-1:0] M     = '0;
    logic         A_bit;
    logic         a_load;
    logic         busy;
    logic         done;
    logic [W-1:0] P;

    logic [W-1:0] ser_a = '0;
    logic [W-1:0] r_ser;

    int n_cmp = 0;
    int n_bad = 0;
    int r_hist [16];
    int cnt;
    int n_done;

    always #5 clk = ~clk;

    // upstream serializer: parallel load on a_load, otherwise shift right, LSB out
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)     r_ser <= '0;
        else if (ena)  r_ser <= a_load ? ser_a : (r_ser >> 1);
    end
    assign A_bit = r_ser[0];

    mont_mult_serial #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .rstb   (rstb),
        .ena    (ena),
        .clear  (clear),
        .start  (start),
        .B      (B),
        .M      (M),
        .A_bit  (A_bit),
        .a_load (a_load),
        .busy   (busy),
        .done   (done),
        .P      (P)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int a, input int b, input int m);
        ser_a = W'(a);
        B     = W'(b);
        M     = W'(m);
        ena   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // counts enabled edges after the start edge until done; optional ena toggling
    task automatic wait_done(input bit tog, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            ena = tog ? ((k % 2) == 1) : 1'b1;
            step();
            if (ena) begin
                n++;
                if (n < 16) r_hist[n] = int'(u_dut.r_acc);
            end
            if (done) break;
        end
        ena = 1'b1;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("rst_P", int'(P), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_aload", int'(a_load), 0);
        #11;
        rstb = 1'b1;
        ena  = 1'b1;
        step();

        // M=13 B=11 A=7
        kick(7, 11, 13);
        chk("c1_aload", int'(a_load), 1);
        chk("c1_busy", int'(busy), 1);
        step();
        chk("c1_aload_low", int'(a_load), 0);
        wait_done(1'b0, cnt);
        chk("c1_lat", cnt + 1, 6);
        chk("c1_R0", r_hist[1], 12);
        chk("c1_R1", r_hist[2], 18);
        chk("c1_R2", r_hist[3], 21);
        chk("c1_R3", r_hist[4], 17);
        chk("c1_P", int'(P), 4);
        step();
        chk("c1_done_drop", int'(done), 0);
        chk("c1_P_hold", int'(P), 4);
        chk("c1_idle", int'(busy), 0);

        // R == M boundary
        kick(15, 14, 15);
        wait_done(1'b0, cnt);
        chk("c2_Rpre", r_hist[5], 15);
        chk("c2_P", int'(P), 0);

        kick(1, 1, 13);
        wait_done(1'b0, cnt);
        chk("c3_P", int'(P), 9);

        kick(0, 12, 13);
        wait_done(1'b0, cnt);
        chk("c3z_lat", cnt, 6);
        chk("c3z_P", int'(P), 0);
        chk("c3z_done", int'(done), 1);

        // ena toggling stretches schedule
        kick(7, 11, 13);
        wait_done(1'b1, cnt);
        chk("c4_lat", cnt, 6);
        chk("c4_P", int'(P), 4);
        ena = 1'b0;
        step();
        chk("c4_done_held", int'(done), 1);
        ena = 1'b1;
        step();
        chk("c4_done_drop", int'(done), 0);

        // clear during iteration 2
        kick(7, 11, 13);
        step();
        step();
        step();
        clear = 1'b0;
        step();
        clear = 1'b1;
        chk("clr_busy", int'(busy), 0);
        chk("clr_P", int'(P), 0);
        chk("clr_done", int'(done), 0);
        chk("clr_aload", int'(a_load), 0);
        n_done = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) n_done++;
        end
        chk("clr_no_done", n_done, 0);

        kick(7, 11, 13);
        wait_done(1'b0, cnt);
        chk("restart_P", int'(P), 4);

        // async reset mid-CALC
        kick(7, 11, 13);
        step();
        step();
        rstb = 1'b0;
        #1;
        chk("arst_P", int'(P), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_aload", int'(a_load), 0);
        #2;
        rstb = 1'b1;
        step();
        kick(1, 1, 13);
        wait_done(1'b0, cnt);
        chk("arst_restart_P", int'(P), 9);

        // start held high, operands changed after LOAD
        ser_a = 4'd7;
        B     = 4'd11;
        M     = 4'd13;
        start = 1'b1;
        step();
        step();
        B     = 4'd1;
        M     = 4'd15;
        ser_a = 4'd1;
        wait_done(1'b0, cnt);
        chk("hold_lat", cnt + 1, 6);
        chk("hold_P1", int'(P), 4);
        step();
        start = 1'b0;
        chk("hold_reload", int'(a_load), 1);
        chk("hold_done_drop", int'(done), 0);
        wait_done(1'b0, cnt);
        chk("hold_lat2", cnt, 6);
        chk("hold_P2", int'(P), 1);
        step();
        chk("hold_no_third", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
